// File: rtl/harris_pkg.sv
// Shared definitions for the Harris detector front end: FSM states, default
// geometry and the flush-length formula that sizes the detector's line buffers.
package harris_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;

  // Two buffered lines plus the window/pipeline tail must drain after the last pixel.
  function automatic int unsigned flush_cycles(input int unsigned img_w);
    return 2 * img_w + 8;
  endfunction

endpackage

// File: rtl/harris_xy_counter.sv
// Column/row position counter with synchronous clear and enable; the column
// wraps into the row, and the last-column / last-pixel flags are combinational.
module harris_xy_counter
  import harris_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     last_col,
  output logic                     last_pix
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer feeding harrisDetector: accepts a valid/ready pixel stream,
// tags position and frame boundaries, then flushes the detector with zero beats.
module harris_frame_ctrl
  import harris_pkg::*;
#(
  parameter int unsigned PIX_W        = DEF_PIX_W,
  parameter int unsigned IMG_W        = DEF_IMG_W,
  parameter int unsigned IMG_H        = DEF_IMG_H,
  parameter int unsigned FLUSH_CYCLES = flush_cycles(IMG_W),
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PIX_W-1:0]         src_pixel,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [PIX_W-1:0]         pixel,
  output logic                     pixel_valid,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     sof,
  output logic                     eol,
  output logic                     eof,
  output logic                     flushing,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int unsigned COL_W   = $clog2(IMG_W);
  localparam int unsigned ROW_W   = $clog2(IMG_H);
  localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned FC_LAST = (FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1;

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [COL_W-1:0]  cnt_col;
  logic [ROW_W-1:0]  cnt_row;
  logic              last_col;
  logic              last_pix;
  logic              xfer;

  assign src_ready = (state == STREAM);
  assign busy      = (state != IDLE);
  assign xfer      = src_valid && src_ready;

  // Counters advance only on accepted pixels; abort wins over a same-cycle transfer.
  harris_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state != STREAM) || abort),
    .enable   (xfer && !abort),
    .col      (cnt_col),
    .row      (cnt_row),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      col         <= '0;
      row         <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      flushing    <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      flushing    <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) state <= STREAM;
        end
        STREAM: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer) begin
            pixel       <= src_pixel;
            pixel_valid <= 1'b1;
            col         <= cnt_col;
            row         <= cnt_row;
            sof         <= (cnt_col == '0) && (cnt_row == '0);
            eol         <= last_col;
            eof         <= last_pix;
            if (last_pix) begin
              if (FLUSH_CYCLES == 0) state <= DONE;
              else                   state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (abort) begin
            state     <= IDLE;
            flush_cnt <= '0;
          end else begin
            pixel       <= '0;
            pixel_valid <= 1'b1;
            flushing    <= 1'b1;
            if (flush_cnt == FC_W'(FC_LAST)) begin
              flush_cnt <= '0;
              state     <= DONE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/harris_frame_ctrl.md
Name: harris_frame_ctrl

Overview:
Frame sequencer in front of harrisDetector. Accepts a pixel stream from a source (file reader, camera or DMA) over a valid/ready handshake and drives the detector's pixel/pixel_valid inputs. Tracks row and column position, marks frame boundaries, and flushes the detector's line-buffer pipeline with zero pixels after the last pixel. Reports busy, done and a frame count to the top level.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 64, pixels per row (must be >= 2)
IMG_H, 64, rows per frame (must be >= 2)
FLUSH_CYCLES, 2*IMG_W+8, zero-pixel beats issued after the last real pixel (0 allowed)
CNT_W, 16, frame counter width

Ports:
clk  in  1  system clock, all logic on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; begins a frame when idle
abort  in  1  one-cycle pulse; cancels the frame in progress
src_pixel  in  PIX_W  source pixel
src_valid  in  1  source pixel available
src_ready  out  1  controller accepts src_pixel this cycle
pixel  out  PIX_W  pixel to harrisDetector
pixel_valid  out  1  pixel qualifier to harrisDetector
col  out  clog2(IMG_W)  column of the current output pixel
row  out  clog2(IMG_H)  row of the current output pixel
sof  out  1  output pixel is (0,0)
eol  out  1  output pixel is the last in its row
eof  out  1  output pixel is the last real pixel of the frame
flushing  out  1  output beat is a flush (zero) beat
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion
frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs and internal counters are 0.
- States: IDLE, STREAM, FLUSH, DONE. src_ready = (state==STREAM), decoded combinationally from the state register. busy = (state!=IDLE).
- IDLE: when start==1 and abort==0, go to STREAM with the internal column/row counters at 0. start is ignored in every other state.
- STREAM:
  - A transfer occurs when src_valid && src_ready.
  - On a transfer, the next cycle shows: pixel=src_pixel, pixel_valid=1, col/row = coordinates of that pixel, sof/eol/eof decoded from those coordinates. Latency is exactly 1 cycle.
  - With no transfer: pixel_valid=0, sof/eol/eof=0, and pixel/col/row hold their values (bubble).
  - Internal column counter wraps IMG_W-1 -> 0 and increments the row counter.
  - On the transfer of pixel (IMG_W-1, IMG_H-1): go to FLUSH, or to DONE if FLUSH_CYCLES==0. src_ready is 0 from the next cycle.
- FLUSH:
  - Each cycle: pixel=0, pixel_valid=1, flushing=1, sof/eol/eof=0, col/row hold.
  - The flush counter runs 0..FLUSH_CYCLES-1. After exactly FLUSH_CYCLES flush beats, go to DONE.
- DONE: one cycle. done=1, frame_cnt increments, pixel_valid=0. Then go to IDLE.
- abort in STREAM or FLUSH: next cycle state IDLE, pixel_valid=0, flushing=0, internal counters cleared. No done pulse; frame_cnt unchanged.
- abort in IDLE or DONE: no effect. DONE still completes and pulses done.
- start and abort together in IDLE: abort wins; stay IDLE.
- Source stalls: any number of src_valid=0 cycles is legal in STREAM. The frame only advances on transfers.
- reset==0 mid-frame: immediate return to the reset state; frame_cnt cleared.

Decomposition:
- Shared package harris_pkg: state encoding (IDLE=0, STREAM=1, FLUSH=2, DONE=3), default IMG_W/IMG_H/PIX_W constants, and the FLUSH_CYCLES formula so harrisDetector and this block agree on line-buffer depth.
- One natural sub-module, harris_xy_counter: column/row counter with wrap, clear and enable, plus last-column and last-pixel flags.

Test Plan:
- IMG_W=4, IMG_H=4, FLUSH_CYCLES=3; start, then src_valid held 1 with pixels 1..16 -> pixel_valid high 16 cycles with pixels 1..16 one cycle after each transfer. sof on pixel 1; eol on 4, 8, 12, 16; eof on 16. Then 3 beats of pixel=0 with flushing=1, then done pulse, frame_cnt=1, busy=0.
- Same config; src_valid toggling 1,0,1,0 -> pixel_valid shows matching 1-cycle bubbles; col/row hold during bubbles; still exactly 16 real pixels and done after 3 flush beats.
- abort on the cycle after the 7th transfer -> next cycle IDLE, pixel_valid=0, no done, frame_cnt unchanged. A following start restarts at (0,0) with sof on the first pixel.
- FLUSH_CYCLES=0 -> done pulses the cycle after the eof beat; flushing never asserts.
- start pulsed during STREAM, and start+abort together in IDLE -> both ignored; state is unchanged.
- reset=0 for 1 cycle mid-FLUSH -> all outputs 0 next cycle including frame_cnt; a subsequent full frame completes normally with frame_cnt=1.
